fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Sequences instruction fetch from the 512x8 instruction ROM by generating the SPARC-style PC/nPC byte address pair each cycle.
- Handles the branch delay slot, annul-bit squashing, pipeline stalls and misaligned-target traps.
- Sits between the instruction ROM address input and the control unit.
- Takes branch resolution from decode and the stall request from hazard logic.

Parameters:
ADDR_W, 9, ROM byte-address width (512 bytes)
RESET_PC, 0, PC value loaded on reset (nPC = RESET_PC+4)
CNT_W, 16, width of the fetched-instruction counter

Ports:
clk  in  1  system clock, all state updates on rising edge
clr  in  1  synchronous active-low reset; sampled on rising edge of clk
stall  in  1  hazard stall request; holds PC/nPC
br_valid  in  1  decode holds a resolved control-transfer instruction this cycle
br_taken  in  1  branch condition true (meaningful only with br_valid)
br_uncond  in  1  branch is unconditional (ba/bn class)
br_annul  in  1  annul bit of the branch in decode
br_target  in  ADDR_W  byte target address of the branch
pc  out  ADDR_W  current fetch address, drives ROM Address
npc  out  ADDR_W  next PC
if_valid  out  1  fetch at pc is valid this cycle
squash  out  1  kill the delay-slot instruction currently in IF (one-cycle pulse)
trap  out  1  sticky misaligned-target trap flag
fetch_cnt  out  CNT_W  number of valid, non-squashed fetches accepted

Behaviour:
- Reset and clock: clk is the single clock. clr is synchronous and active-low; it overrides all other inputs, including mid-stall and mid-branch.
- Reset values (clr=0 at a rising edge):
  - pc=RESET_PC, npc=RESET_PC+4, if_valid=0, squash=0, trap=0, fetch_cnt=0.
  - State=IDLE.
- Registered outputs: all outputs are registered; no combinational path from inputs to outputs.
- IDLE:
  - Lasts one cycle after clr deasserts.
  - Then RUN with if_valid=1 and pc=RESET_PC.
- RUN, stall=0, br_valid=0:
  - pc<=npc, npc<=npc+4.
  - Addition is modulo 2^ADDR_W, so 508 wraps to 0.
- RUN, stall=0, br_valid=1, br_taken=1:
  - The delay slot was already fetched at the current pc.
  - pc<=br_target, npc<=br_target+4 (mod 2^ADDR_W).
- RUN, stall=0, br_valid=1, br_taken=0:
  - Sequential update, same as no branch.
- Squash:
  - squash<=1 for exactly one cycle when stall=0 & br_valid & br_annul & (~br_taken | br_uncond).
  - Otherwise squash<=0.
  - This follows SPARC annul semantics: untaken annulled branches and ba,a both kill the delay slot.
- STALL (RUN with stall=1):
  - pc, npc, if_valid and fetch_cnt hold.
  - squash<=0.
  - br_* inputs are ignored; decode must keep br_valid asserted until a non-stall cycle. Stall wins over a simultaneous branch.
  - Return to RUN on the first cycle with stall=0.
- Misaligned target:
  - Trigger: br_valid & br_taken & stall=0 & br_target[1:0]!=0.
  - Enter TRAP: trap<=1, if_valid<=0, pc/npc hold their pre-branch values, squash<=0.
  - TRAP is absorbing; only clr exits it.
- fetch_cnt:
  - Increments on each RUN cycle with stall=0 and if_valid=1, except a cycle whose squash output is 1.
  - Saturates at all-ones; no wrap.
- Alignment: pc and npc are always 4-byte aligned in IDLE and RUN.
- FSM: IDLE -> RUN; RUN <-> STALL; RUN -> TRAP; any state -> IDLE on clr=0.

Decomposition:
- Shared package fetch_pkg:
  - State encoding enum (IDLE, RUN, STALL, TRAP).
  - INSN_BYTES=4 constant.
  - Alignment-check function.
- Sub-module npc_adder: ADDR_W-bit +4/target select, combinational.
- FSM, squash logic and counter stay in the top module.

Test Plan:
- Reset/start: clr=0 for 2 cycles, then 1 -> cycle 0: pc=0, npc=4, if_valid=0. Next cycle if_valid=1, pc=0. Then pc=4, 8, 12 on successive cycles; fetch_cnt counts 1, 2, 3.
- Taken branch with delay slot: at pc=8 (npc=12), br_valid=1, br_taken=1, br_target=40 -> next pc=40, npc=44, squash=0.
- Annul cases:
  - br_annul=1, br_taken=0, br_uncond=0 at pc=16 -> squash=1 for one cycle, pc=20, fetch_cnt not incremented for that cycle.
  - br_uncond=1, br_annul=1, br_taken=1, target=100 -> squash=1, pc=100.
- Stall vs branch: stall=1 and br_valid=1, br_target=64 for 3 cycles -> pc/npc/fetch_cnt frozen. On stall=0 with br_valid still 1 -> pc=64, npc=68.
- Wrap and trap:
  - Free-run to pc=508 -> next pc=0, npc=4.
  - Taken branch with br_target=42 -> trap=1, if_valid=0, pc held.
  - Trap persists until clr=0, after which the reset values are restored.
- Reset mid-operation: clr=0 during STALL with squash pending -> next edge gives all reset values, squash=0, trap=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg : shared constants, state encoding and helpers for fetch_sequencer
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  localparam int INSN_BYTES = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;
  localparam logic [1:0] ST_TRAP  = 2'd3;

  typedef logic [1:0] fetch_state_t;

  function automatic logic is_aligned(input logic [1:0] addr_lsbs);
    return addr_lsbs == 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_npc_adder.sv
// ---------------------------------------------------------------------------
// npc_adder : selects sequential or branch-target PC and forms the matching nPC
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module npc_adder
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic [ADDR_W-1:0] seq_pc,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              take_br,
  output logic [ADDR_W-1:0] next_pc,
  output logic [ADDR_W-1:0] next_npc
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSN_BYTES);

  // Sum is truncated to ADDR_W bits so the address space wraps naturally.
  always_comb begin
    next_pc  = take_br ? br_target : seq_pc;
    next_npc = next_pc + STEP;
  end

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer : SPARC-style PC/nPC fetch sequencer with delay slot, annul
//                   squashing, stall hold and misaligned-target trap
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              stall,
  input  logic              br_valid,
  input  logic              br_taken,
  input  logic              br_uncond,
  input  logic              br_annul,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc,
  output logic              if_valid,
  output logic              squash,
  output logic              trap,
  output logic [CNT_W-1:0]  fetch_cnt
);

  localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] NPC_RST = ADDR_W'(RESET_PC + INSN_BYTES);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, npc_q, npc_d;
  logic              if_valid_q, if_valid_d;
  logic              squash_q, squash_d;
  logic              trap_q, trap_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              take_br;
  logic              misaligned;
  logic [ADDR_W-1:0] next_pc, next_npc;

  assign take_br    = br_valid & br_taken;
  assign misaligned = take_br & ~is_aligned(br_target[1:0]);

  npc_adder #(
    .ADDR_W (ADDR_W)
  ) u_npc_adder (
    .seq_pc    (npc_q),
    .br_target (br_target),
    .take_br   (take_br),
    .next_pc   (next_pc),
    .next_npc  (next_npc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    npc_d      = npc_q;
    if_valid_d = if_valid_q;
    squash_d   = 1'b0;
    trap_d     = trap_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE: begin
        state_d    = ST_RUN;
        if_valid_d = 1'b1;
      end
      ST_RUN, ST_STALL: begin
        if (stall) begin
          state_d = ST_STALL;
        end else begin
          // The instruction at pc is accepted unless it is a killed delay slot.
          if (if_valid_q && !squash_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_ONE;
          end
          if (misaligned) begin
            state_d    = ST_TRAP;
            trap_d     = 1'b1;
            if_valid_d = 1'b0;
          end else begin
            state_d  = ST_RUN;
            pc_d     = next_pc;
            npc_d    = next_npc;
            squash_d = br_valid & br_annul & (~br_taken | br_uncond);
          end
        end
      end
      default: begin
        state_d = ST_TRAP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q    <= ST_IDLE;
      pc_q       <= PC_RST;
      npc_q      <= NPC_RST;
      if_valid_q <= 1'b0;
      squash_q   <= 1'b0;
      trap_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      npc_q      <= npc_d;
      if_valid_q <= if_valid_d;
      squash_q   <= squash_d;
      trap_q     <= trap_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc        = pc_q;
  assign npc       = npc_q;
  assign if_valid  = if_valid_q;
  assign squash    = squash_q;
  assign trap      = trap_q;
  assign fetch_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer : directed bench with a behavioural reference model
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_sequencer;

  localparam int AW      = 9;
  localparam int CW      = 6;
  localparam int RST_PC  = 0;
  localparam int ROM     = 1 << AW;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          clr, stall, br_valid, br_taken, br_uncond, br_annul;
  logic [AW-1:0] br_target;
  logic [AW-1:0] pc, npc;
  logic          if_valid, squash, trap;
  logic [CW-1:0] fetch_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int m_pc, m_npc, m_cnt;
  bit m_valid, m_squash, m_trap, m_started;

  fetch_sequencer #(
    .ADDR_W   (AW),
    .RESET_PC (RST_PC),
    .CNT_W    (CW)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .stall     (stall),
    .br_valid  (br_valid),
    .br_taken  (br_taken),
    .br_uncond (br_uncond),
    .br_annul  (br_annul),
    .br_target (br_target),
    .pc        (pc),
    .npc       (npc),
    .if_valid  (if_valid),
    .squash    (squash),
    .trap      (trap),
    .fetch_cnt (fetch_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: applies the architectural rules to plain integers.
  always @(posedge clk) begin
    if (!clr) begin
      m_pc = RST_PC; m_npc = RST_PC + 4; m_cnt = 0;
      m_valid = 0; m_squash = 0; m_trap = 0; m_started = 0;
    end else if (m_trap) begin
    end else if (!m_started) begin
      m_started = 1; m_valid = 1; m_squash = 0;
    end else if (stall) begin
      m_squash = 0;
    end else begin
      if (m_valid && !m_squash && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (br_valid && br_taken && (int'(br_target) % 4) != 0) begin
        m_trap = 1; m_valid = 0; m_squash = 0;
      end else begin
        m_squash = br_valid && br_annul && (!br_taken || br_uncond);
        if (br_valid && br_taken) begin
          m_pc  = int'(br_target);
          m_npc = (int'(br_target) + 4) % ROM;
        end else begin
          m_pc  = m_npc;
          m_npc = (m_npc + 4) % ROM;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks = checks + 1;
      if (pc !== AW'(m_pc) || npc !== AW'(m_npc) || if_valid !== m_valid ||
          squash !== m_squash || trap !== m_trap || fetch_cnt !== CW'(m_cnt)) begin
        errors = errors + 1;
        $display("FAIL model_cmp t=%0t got pc=%0d npc=%0d v=%0b sq=%0b tr=%0b cnt=%0d want pc=%0d npc=%0d v=%0b sq=%0b tr=%0b cnt=%0d",
                 $time, pc, npc, if_valid, squash, trap, fetch_cnt,
                 m_pc, m_npc, m_valid, m_squash, m_trap, m_cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input int e_pc, input int e_npc,
                           input int e_v, input int e_sq, input int e_tr, input int e_cnt);
    chk({name, ".pc"},  32'(pc),        32'(e_pc));
    chk({name, ".npc"}, 32'(npc),       32'(e_npc));
    chk({name, ".v"},   32'(if_valid),  32'(e_v));
    chk({name, ".sq"},  32'(squash),    32'(e_sq));
    chk({name, ".tr"},  32'(trap),      32'(e_tr));
    chk({name, ".cnt"}, 32'(fetch_cnt), 32'(e_cnt));
  endtask

  task automatic set_br(input logic v, input logic t, input logic u, input logic a,
                        input int tgt);
    br_valid = v; br_taken = t; br_uncond = u; br_annul = a; br_target = AW'(tgt);
  endtask

  initial begin
    clr = 1'b0; stall = 1'b0;
    set_br(0, 0, 0, 0, 0);
    tick(); tick();
    chk_en = 1'b1;
    chk_state("reset", 0, 4, 0, 0, 0, 0);

    clr = 1'b1;
    tick();
    chk_state("idle_exit", 0, 4, 1, 0, 0, 0);
    tick();
    chk_state("seq4", 4, 8, 1, 0, 0, 1);
    tick();
    chk_state("seq8", 8, 12, 1, 0, 0, 2);

    set_br(1, 1, 0, 0, 40);
    tick();
    chk_state("taken40", 40, 44, 1, 0, 0, 3);

    set_br(1, 1, 0, 0, 16);
    tick();
    chk_state("taken16", 16, 20, 1, 0, 0, 4);

    set_br(1, 0, 0, 1, 200);
    tick();
    chk_state("annul_untaken", 20, 24, 1, 1, 0, 5);
    set_br(0, 0, 0, 0, 0);
    tick();
    chk_state("after_annul", 24, 28, 1, 0, 0, 5);

    set_br(1, 1, 1, 1, 100);
    tick();
    chk_state("ba_a", 100, 104, 1, 1, 0, 6);
    set_br(0, 0, 0, 0, 0);
    tick();
    chk_state("after_ba_a", 104, 108, 1, 0, 0, 6);

    stall = 1'b1;
    set_br(1, 1, 0, 0, 64);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state("stall_hold", 104, 108, 1, 0, 0, 6);
    end
    stall = 1'b0;
    tick();
    chk_state("stall_release", 64, 68, 1, 0, 0, 7);

    set_br(1, 1, 0, 0, 500);
    tick();
    chk_state("to500", 500, 504, 1, 0, 0, 8);
    set_br(0, 0, 0, 0, 0);
    tick(); tick();
    chk_state("at508", 508, 0, 1, 0, 0, 10);
    tick();
    chk_state("wrap", 0, 4, 1, 0, 0, 11);

    for (int i = 0; i < 60; i++) tick();
    chk_state("saturate", 240, 244, 1, 0, 0, CNT_MAX);

    set_br(1, 1, 0, 0, 42);
    tick();
    chk_state("trap", 240, 244, 0, 0, 1, CNT_MAX);
    set_br(1, 1, 1, 1, 80);
    tick();
    stall = 1'b1;
    tick();
    stall = 1'b0;
    set_br(0, 0, 0, 0, 0);
    tick();
    chk_state("trap_sticky", 240, 244, 0, 0, 1, CNT_MAX);

    clr = 1'b0;
    tick();
    chk_state("trap_clr", 0, 4, 0, 0, 0, 0);
    clr = 1'b1;
    tick();
    chk_state("restart", 0, 4, 1, 0, 0, 0);
    tick();
    set_br(1, 0, 0, 1, 300);
    tick();
    chk_state("annul2", 8, 12, 1, 1, 0, 2);
    stall = 1'b1;
    tick();
    chk_state("stall2", 8, 12, 1, 0, 0, 2);
    clr = 1'b0;
    tick();
    chk_state("clr_in_stall", 0, 4, 0, 0, 0, 0);
    clr = 1'b1; stall = 1'b0;
    set_br(0, 0, 0, 0, 0);
    tick(); tick();
    chk_state("final", 4, 8, 1, 0, 0, 1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
